// File: rtl/digit_entry.sv
// Three-digit decimal answer entry: btn_inc steps the active digit, btn_ok commits it.
// The third commit publishes the binary answer; per-digit inactivity aborts the entry.
module digit_entry #(
  parameter int TIMEOUT_TICKS = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       btn_inc_i,
  input  logic       btn_ok_i,
  output logic [1:0] digit_idx_o,
  output logic [3:0] digit_val_o,
  output logic [9:0] answer_o,
  output logic       answer_valid_o,
  output logic       timeout_o,
  output logic       busy_o
);

  localparam int TW = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ENTRY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          inc_q, ok_q;
  logic [9:0]    acc_q, acc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [3:0]    digit_val_q, digit_val_d;
  logic [9:0]    answer_q, answer_d;
  logic          answer_valid_q, answer_valid_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;

  logic          inc_edge, ok_edge;
  logic [9:0]    commit_sum;

  assign inc_edge   = btn_inc_i & ~inc_q;
  assign ok_edge    = btn_ok_i & ~ok_q;
  // acc never exceeds 99 before the last commit, so this stays within 999.
  assign commit_sum = (acc_q * 10'd10) + {6'd0, digit_val_q};

  // Previous button levels; reset high so a button held through reset never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q <= 1'b1;
      ok_q  <= 1'b1;
    end else begin
      inc_q <= btn_inc_i;
      ok_q  <= btn_ok_i;
    end
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      acc_q          <= 10'd0;
      timer_q        <= '0;
      digit_idx_q    <= 2'd3;
      digit_val_q    <= 4'd0;
      answer_q       <= 10'd0;
      answer_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      timer_q        <= timer_d;
      digit_idx_q    <= digit_idx_d;
      digit_val_q    <= digit_val_d;
      answer_q       <= answer_d;
      answer_valid_q <= answer_valid_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state and next-output logic; ok beats inc, any edge beats expiry.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    timer_d        = timer_q;
    digit_idx_d    = digit_idx_q;
    digit_val_d    = digit_val_q;
    answer_d       = answer_q;
    answer_valid_d = 1'b0;
    timeout_d      = 1'b0;
    busy_d         = busy_q;

    case (state_q)
      S_IDLE: begin
        digit_idx_d = 2'd3;
        busy_d      = 1'b0;
        if (start_i) begin
          state_d     = S_ENTRY;
          digit_idx_d = 2'd0;
          digit_val_d = 4'd0;
          acc_d       = 10'd0;
          timer_d     = '0;
          busy_d      = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ENTRY: begin
        busy_d = 1'b1;
        if (ok_edge) begin
          if (digit_idx_q == 2'd2) begin
            answer_d       = commit_sum;
            answer_valid_d = 1'b1;
            digit_idx_d    = 2'd3;
            digit_val_d    = 4'd0;
            timer_d        = '0;
            busy_d         = 1'b0;
            state_d        = S_IDLE;
          end else begin
            acc_d       = commit_sum;
            digit_idx_d = digit_idx_q + 2'd1;
            digit_val_d = 4'd0;
            timer_d     = '0;
          end
        end else if (inc_edge) begin
          digit_val_d = (digit_val_q == 4'd9) ? 4'd0 : (digit_val_q + 4'd1);
          timer_d     = '0;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d   = 1'b1;
          digit_idx_d = 2'd3;
          digit_val_d = 4'd0;
          timer_d     = '0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        digit_idx_d = 2'd3;
        digit_val_d = 4'd0;
        timer_d     = '0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign digit_idx_o    = digit_idx_q;
  assign digit_val_o    = digit_val_q;
  assign answer_o       = answer_q;
  assign answer_valid_o = answer_valid_q;
  assign timeout_o      = timeout_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: directed scenarios plus random button traffic, all checked
// every cycle against a digit-array reference model kept in the bench.
module tb_digit_entry;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_ok = 1'b0;
  logic [1:0] digit_idx;
  logic [3:0] digit_val;
  logic [9:0] answer;
  logic       answer_valid;
  logic       timeout;
  logic       busy;

  int n_total = 0;
  int n_bad = 0;

  // reference model state
  bit m_busy;
  int m_idx, m_val, m_quiet, m_answer;
  int m_digits[3];
  bit m_valid, m_tmo, m_prev_inc, m_prev_ok;

  digit_entry #(.TIMEOUT_TICKS(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .btn_inc_i      (btn_inc),
    .btn_ok_i       (btn_ok),
    .digit_idx_o    (digit_idx),
    .digit_val_o    (digit_val),
    .answer_o       (answer),
    .answer_valid_o (answer_valid),
    .timeout_o      (timeout),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_idx = 3; m_val = 0; m_quiet = 0; m_answer = 0;
    m_valid = 1'b0; m_tmo = 1'b0; m_prev_inc = 1'b1; m_prev_ok = 1'b1;
    for (int k = 0; k < 3; k++) m_digits[k] = 0;
  endtask

  // One clock of the player-level rules, given the input levels seen at that edge.
  task automatic model_step(input bit s, input bit i, input bit o);
    bit ie, oe;
    ie = i && !m_prev_inc;
    oe = o && !m_prev_ok;
    m_prev_inc = i;
    m_prev_ok = o;
    m_valid = 1'b0;
    m_tmo = 1'b0;
    if (!m_busy) begin
      if (s) begin
        m_busy = 1'b1; m_idx = 0; m_val = 0; m_quiet = 0;
      end
    end else if (oe) begin
      m_digits[m_idx] = m_val;
      m_val = 0;
      m_quiet = 0;
      if (m_idx == 2) begin
        m_answer = m_digits[0] * 100 + m_digits[1] * 10 + m_digits[2];
        m_valid = 1'b1; m_busy = 1'b0; m_idx = 3;
      end else begin
        m_idx++;
      end
    end else if (ie) begin
      m_val = (m_val + 1) % 10;
      m_quiet = 0;
    end else begin
      m_quiet++;
      if (m_quiet == TO) begin
        m_tmo = 1'b1; m_busy = 1'b0; m_idx = 3; m_val = 0;
      end
    end
  endtask

  task automatic cmp_all();
    chk("digit_idx", digit_idx, m_idx);
    chk("digit_val", digit_val, m_val);
    chk("answer", answer, m_answer);
    chk("answer_valid", answer_valid, m_valid);
    chk("timeout", timeout, m_tmo);
    chk("busy", busy, m_busy);
  endtask

  task automatic step(input bit s, input bit i, input bit o);
    start = s; btn_inc = i; btn_ok = o;
    @(posedge clk);
    #1;
    model_step(s, i, o);
    cmp_all();
  endtask

  task automatic press_inc();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_ok();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3 * TO) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("idle_bound", busy, 1'b0);
  endtask

  initial begin
    bit i, o, s;
    int pct;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    cmp_all();
    chk("rst_idx", digit_idx, 2'd3);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // 3,0,7 -> 307
    step(1'b1, 1'b0, 1'b0);
    repeat (3) press_inc();
    press_ok();
    press_ok();
    repeat (7) press_inc();
    step(1'b0, 1'b0, 1'b1);
    chk("ans307", answer, 10'd307);
    chk("valid307", answer_valid, 1'b1);
    chk("idx_after307", digit_idx, 2'd3);
    step(1'b0, 1'b0, 1'b0);
    chk("valid_1cyc", answer_valid, 1'b0);

    // wrap after 12 edges; a held button counts once
    step(1'b1, 1'b0, 1'b0);
    repeat (12) press_inc();
    chk("wrap12", digit_val, 4'd2);
    repeat (15) step(1'b0, 1'b1, 1'b0);
    chk("held_once", digit_val, 4'd3);
    step(1'b0, 1'b0, 1'b0);
    wait_idle();

    // timeout TO cycles after entering
    step(1'b1, 1'b0, 1'b0);
    repeat (TO - 1) step(1'b0, 1'b0, 1'b0);
    chk("tmo_early", timeout, 1'b0);
    chk("busy_early", busy, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("tmo_pulse", timeout, 1'b1);
    chk("tmo_ans_kept", answer, 10'd307);
    chk("tmo_idx", digit_idx, 2'd3);
    step(1'b0, 1'b0, 1'b0);
    chk("tmo_1cyc", timeout, 1'b0);

    // inc and ok together: ok wins
    step(1'b1, 1'b0, 1'b0);
    repeat (4) press_inc();
    step(1'b0, 1'b1, 1'b1);
    chk("both_idx", digit_idx, 2'd1);
    chk("both_val", digit_val, 4'd0);
    step(1'b0, 1'b0, 1'b0);
    press_ok();
    step(1'b0, 1'b0, 1'b1);
    chk("ans400", answer, 10'd400);
    step(1'b0, 1'b0, 1'b0);

    // ok on the expiry cycle suppresses the timeout
    step(1'b1, 1'b0, 1'b0);
    repeat (TO - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("exp_no_tmo", timeout, 1'b0);
    chk("exp_idx", digit_idx, 2'd1);
    step(1'b0, 1'b0, 1'b0);
    wait_idle();

    // reset mid-entry, start ignored while busy
    step(1'b1, 1'b0, 1'b0);
    press_inc();
    press_ok();
    press_inc();
    press_inc();
    step(1'b1, 1'b0, 1'b0);
    chk("start_ignored", digit_idx, 2'd1);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk("restart_idx", digit_idx, 2'd0);
    chk("restart_busy", busy, 1'b1);

    // random traffic with varying activity levels
    for (int seg = 0; seg < 12; seg++) begin
      pct = $urandom_range(5, 60);
      for (int c = 0; c < 200; c++) begin
        s = ($urandom_range(0, 99) < 10);
        i = ($urandom_range(0, 99) < pct) ? !btn_inc : btn_inc;
        o = ($urandom_range(0, 99) < pct / 3) ? !btn_ok : btn_ok;
        step(s, i, o);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
